// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: FSM state encodings and default operand width for serial_addsub
package serial_addsub_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/serial_addsub_full_adder.sv
// full_adder: single-bit full adder slice
//   Ai, Bi, Cini : addend bits and carry in
//   Di, Couti    : sum bit and carry out
module full_adder (
    input  logic Ai,
    input  logic Bi,
    input  logic Cini,
    output logic Di,
    output logic Couti
);
    assign Di    = Ai ^ Bi ^ Cini;
    assign Couti = (Ai & Bi) | (Cini & (Ai ^ Bi));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor, one full_adder slice over WIDTH cycles
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, sampled only in IDLE, together with sub/A/B
//   sub          : 0 = A+B, 1 = A-B (computed as A + ~B + 1)
//   A, B         : operands
//   busy         : high in RUN and DONE
//   done         : one-cycle pulse, D/Cout/Ovf valid
//   D, Cout, Ovf : result, carry out of MSB, signed overflow
//   SERIAL_ADDSUB_OVF_EN : when defined, Ovf is computed; otherwise Ovf is tied 0
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Cout,
    output logic             Ovf
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    // Only the upper WIDTH-1 result bits are kept; the final bit joins them on the last edge.
    logic [WIDTH-2:0] d_sr;
    logic             carry, di, co, last;

    full_adder u_fa (
        .Ai   (a_sr[0]),
        .Bi   (b_sr[0]),
        .Cini (carry),
        .Di   (di),
        .Couti(co)
    );

    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state != ST_IDLE;
    assign done = state == ST_DONE;

    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_next;

    always_comb begin
        state_next = state;
        state_next = (state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
                     (state == ST_RUN)  ? (last ? ST_DONE : ST_RUN)  : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Cout  <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            a_sr  <= A;
            b_sr  <= sub ? ~B : B;
            carry <= sub;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            d_sr  <= (WIDTH-1)'({di, d_sr} >> 1);
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                D    <= {di, d_sr};
                Cout <= co;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the last RUN edge the carry register holds the carry into the MSB slice.
    logic ovf_q;
    always_ff @(posedge clk)
        ovf_q <= rst ? 1'b0 : (state == ST_RUN && last) ? (carry ^ co) : ovf_q;
    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub with arithmetic reference model
module tb_serial_addsub;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] d;

    int   n_cmp = 0, n_bad = 0, cyc = 0;
    exp_t sb[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b),
        .busy(busy), .done(done), .D(d), .Cout(cout), .Ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        logic [W:0] r;
        r = s ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
        e.d = r[W-1:0];
        e.cout = s ? (x >= y) : r[W];
`ifdef SERIAL_ADDSUB_OVF_EN
        e.ovf = s ? (x[W-1] != y[W-1] && e.d[W-1] != x[W-1])
                  : (x[W-1] == y[W-1] && e.d[W-1] != x[W-1]);
`else
        e.ovf = 1'b0;
`endif
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done with empty scoreboard, expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("D", 64'(d), 64'(e.d));
                chk("Cout", 64'(cout), 64'(e.cout));
                chk("Ovf", 64'(ovf), 64'(e.ovf));
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", 64'(busy), 64'd1);
            end
        end
    end

    // Issue a start for one cycle; expected result is queued with its done cycle.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        e = model(x, y, s);
        e.cyc = cyc + W;
        sb.push_back(e);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", 3 * W);
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        issue(x, y, s);
        wait_done();
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        exp_t e0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_D", 64'(d), 64'd0);
        chk("rst_Cout", 64'(cout), 64'd0);
        chk("rst_Ovf", 64'(ovf), 64'd0);
        repeat (5) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        op(32'h5, 32'h3, 1'b0);
        op(32'hFFFF_FFFF, 32'h1, 1'b0);
        op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        op(32'h3, 32'h5, 1'b1);
        op(32'h7FFF_FFFF, 32'h1, 1'b0);
        op(32'h8000_0000, 32'h1, 1'b1);
        op(32'h1234_5678, 32'h1234_5678, 1'b1);

        // Starts during RUN and DONE must be ignored.
        issue(32'h0000_1000, 32'h0000_0234, 1'b0);
        e0 = model(32'h0000_1000, 32'h0000_0234, 1'b0);
        repeat (10) @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        a = 32'hCAFE_0000; b = 32'h0000_00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_busy", 64'(busy), 64'd0);
        repeat (2 * W) @(negedge clk);
        chk("ignored_D_held", 64'(d), 64'(e0.d));
        chk("ignored_idle", 64'(busy), 64'd0);

        // Reset mid-RUN discards the operation.
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_D", 64'(d), 64'd0);
        chk("midrst_Cout", 64'(cout), 64'd0);
        chk("midrst_Ovf", 64'(ovf), 64'd0);
        repeat (2 * W) @(negedge clk);
        op(32'h1, 32'h1, 1'b0);

        // Randomised operations; back-to-back where gap is 0.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if (i % 8 == 0) y = x;
            issue(x, y, 1'(i % 3 == 0 ? 1 : $urandom_range(0, 1)));
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (W + 4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
